insn_sequencer: RTL

INSN_SEQUENCER -- requirements
Module: insn_sequencer

---
 rtl/insn_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/insn_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// insn_sequencer
//
// Purpose: cycle-state register, instruction register and bus-cycle watchdog
// for a small RISC-V style core. The external decoders look at cstate_o/ir_o
// and ask for the next state, an IR load or a data bus cycle. This block
// decides on each edge whether that request completes, stalls, times out or
// traps as an illegal instruction.
//
// Parameters:
//   RESET_IR     IR contents after reset (default ADDI x0,x0,0)
//   BUS_TIMEOUT  unacknowledged bus cycles before an access fault (2..255)
//
// Ports:
//   clk_i, reset_i  clock, synchronous active-high reset
//   nstate_i        next cycle state requested by the decoders
//   defined_i       decoders recognise IR in the current cstate
//   ir_dat_irl_i    fetch: load IR from dat_i when acknowledged
//   bus_req_i       non-fetch bus cycle requested
//   ack_i, dat_i    bus acknowledge and read data
//   cstate_o        current cycle state (registered)
//   ir_o            instruction register (registered)
//   cyc_o, stall_o  bus cycle active / waiting for ack (combinational)
//   trap_o          one-cycle trap pulse (registered)
//   cause_o         mcause code of the last trap (registered)
//   retire_o        one-cycle pulse when IR is latched (registered)
// -----------------------------------------------------------------------------
module insn_sequencer #(
  parameter logic [31:0] RESET_IR    = 32'h0000_0013,
  parameter int          BUS_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [2:0]  nstate_i,
  input  logic        defined_i,
  input  logic        ir_dat_irl_i,
  input  logic        bus_req_i,
  input  logic        ack_i,
  input  logic [31:0] dat_i,
  output logic [2:0]  cstate_o,
  output logic [31:0] ir_o,
  output logic        cyc_o,
  output logic        stall_o,
  output logic        trap_o,
  output logic [3:0]  cause_o,
  output logic        retire_o
);

  // Cycle state the core restarts from (instruction fetch).
  localparam logic [2:0] CS_FETCH      = 3'd3;
  localparam logic [7:0] CNT_LAST      = 8'(BUS_TIMEOUT - 1);
  localparam logic [3:0] CAUSE_IFAULT  = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_LFAULT  = 4'd5;

  // What happens at the coming edge; the encoding order is the priority order.
  typedef enum logic [2:0] {
    EV_RESET,
    EV_ILLEGAL,
    EV_TIMEOUT,
    EV_ACK,
    EV_STALL,
    EV_IDLE
  } edge_event_t;

  logic [2:0]  cstate_reg, cstate_next;
  logic [31:0] ir_reg,     ir_next;
  logic [3:0]  cause_reg,  cause_next;
  logic [7:0]  cnt_reg,    cnt_next;
  logic        trap_reg,   trap_next;
  logic        retire_reg, retire_next;
  edge_event_t ev;

  // ---------------------------------------------------------------------------
  // Combinational bus outputs. Reset masks the request so no bus cycle is
  // started while the core is held.
  // ---------------------------------------------------------------------------
  always_comb begin
    cyc_o   = (bus_req_i | ir_dat_irl_i) & ~reset_i;
    stall_o = cyc_o & ~ack_i;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    // An ack on the last allowed cycle wins over the timeout because the
    // timeout term requires stall_o, which is low when ack_i is high.
    if (reset_i)                             ev = EV_RESET;
    else if (!defined_i)                     ev = EV_ILLEGAL;
    else if (stall_o && cnt_reg == CNT_LAST) ev = EV_TIMEOUT;
    else if (cyc_o && ack_i)                 ev = EV_ACK;
    else if (cyc_o)                          ev = EV_STALL;
    else                                     ev = EV_IDLE;
  end

  always_comb begin
    cstate_next = cstate_reg;
    ir_next     = ir_reg;
    cause_next  = cause_reg;
    cnt_next    = 8'd0;       // cleared unless actively stalling
    trap_next   = 1'b0;       // pulses are re-armed every cycle
    retire_next = 1'b0;
    case (ev)
      EV_RESET: begin
        cstate_next = CS_FETCH;
        ir_next     = RESET_IR;
        cause_next  = 4'd0;
      end
      EV_ILLEGAL: begin
        // IR is left alone even if the bus acknowledges a fetch this cycle.
        cstate_next = CS_FETCH;
        trap_next   = 1'b1;
        cause_next  = CAUSE_ILLEGAL;
      end
      EV_TIMEOUT: begin
        cstate_next = CS_FETCH;
        trap_next   = 1'b1;
        cause_next  = ir_dat_irl_i ? CAUSE_IFAULT : CAUSE_LFAULT;
      end
      EV_ACK: begin
        cstate_next = nstate_i;
        if (ir_dat_irl_i) begin
          ir_next     = dat_i;
          retire_next = 1'b1;
        end
      end
      EV_STALL: begin
        cnt_next = cnt_reg + 8'd1;
      end
      EV_IDLE: begin
        cstate_next = nstate_i;
      end
      default: begin
        cstate_next = CS_FETCH;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    cstate_reg <= cstate_next;
    ir_reg     <= ir_next;
    cause_reg  <= cause_next;
    cnt_reg    <= cnt_next;
    trap_reg   <= trap_next;
    retire_reg <= retire_next;
  end

  // ---------------------------------------------------------------------------
  // Registered outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    cstate_o = cstate_reg;
    ir_o     = ir_reg;
    cause_o  = cause_reg;
    trap_o   = trap_reg;
    retire_o = retire_reg;
  end

endmodule
